// File: rtl/vga_sync_pipeline.sv
// Purpose : VGA timing generator (pixel-tick divider, x/y counters, sync/blank
//           decode) with a sync/blank delay line matched to an external pixel
//           generator, plus the registered, blanked RGB stage for the DAC.
// Latency : x/y -> hsync/vsync/rgb is PIPE_DEPTH+1 pixel ticks; rgb_in sampled
//           on a tick appears on rgb after that same clk edge.
// Backpressure: none; the raster free-runs and downstream must keep up.
// Ports   : clk_100MHz, reset (synchronous, active-high), rgb_in (generator
//           colour, PIPE_DEPTH ticks behind x/y); p_tick, x, y, video_on,
//           line_start, frame_start drive the generator; hsync, vsync, rgb are
//           registered outputs for the connector.
module vga_sync_pipeline #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DEPTH = 0,
  parameter int XY_W       = 10,
  parameter int RGB_W      = 12
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             p_tick,
  output logic [XY_W-1:0]  x,
  output logic [XY_W-1:0]  y,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XY_W-1:0]  H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0]  V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0]  H_ACT    = XY_W'(H_DISPLAY);
  localparam logic [XY_W-1:0]  V_ACT    = XY_W'(V_DISPLAY);
  localparam logic [XY_W-1:0]  HS_FIRST = XY_W'(H_DISPLAY + H_FRONT);
  localparam logic [XY_W-1:0]  HS_LAST  = XY_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [XY_W-1:0]  VS_FIRST = XY_W'(V_DISPLAY + V_FRONT);
  localparam logic [XY_W-1:0]  VS_LAST  = XY_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Flags carried through the delay line as "active" bits; polarity is only
  // applied at the output register, so a cleared stage is always inactive.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } flags_t;

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] r_div;
  logic             w_div_last;
  logic             w_tick;

  assign w_div_last = (r_div == DIV_LAST);
  // Gated by reset so no tick is seen while the block is held in reset.
  assign w_tick     = w_div_last && !reset;

  always_ff @(posedge clk_100MHz) begin
    if (reset || w_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // --------------------------------------------------------------- counters
  logic [XY_W-1:0] r_x;
  logic [XY_W-1:0] r_y;
  logic            w_x_wrap;
  logic            w_y_wrap;

  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_tick) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------- raw flags
  flags_t w_raw;

  assign w_raw.vid = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_raw.hs  = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
  assign w_raw.vs  = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

  // ------------------------------------------------------------- delay line
  flags_t w_dly;

  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign w_dly = w_raw;
    end else begin : g_pipe
      flags_t r_pipe [PIPE_DEPTH];

      // Reset clears every stage so nothing captured before a mid-frame
      // reset can surface on the outputs after release.
      always_ff @(posedge clk_100MHz) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_pipe[i] <= '0;
          end
        end else if (w_tick) begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_dly = r_pipe[PIPE_DEPTH-1];
    end
  endgenerate

  // -------------------------------------------------------- output register
  logic             r_hsync;
  logic             r_vsync;
  logic [RGB_W-1:0] r_rgb;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_rgb   <= '0;
    end else if (w_tick) begin
      r_hsync <= w_dly.hs ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_dly.vs ? VSYNC_POL : ~VSYNC_POL;
      r_rgb   <= w_dly.vid ? rgb_in : '0;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign p_tick      = w_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = w_raw.vid;
  assign line_start  = w_tick && (r_x == '0);
  assign frame_start = w_tick && (r_x == '0) && (r_y == '0);
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign rgb         = r_rgb;

endmodule
